// File: rtl/shift_seq.sv
// ---------------------------------------------------------------------------
// shift_seq -- multi-cycle 16-bit shift/rotate sequencer.
//
// One power-of-two shifter stage is reused over up to four cycles. The stage
// shifts by 8, 4, 2 and 1 in turn, and each stage is applied only when the
// matching bit of the captured count is set. The final value lands in a
// holding register that changes only on completion or reset.
//
// Parameters:
//   EARLY_EXIT  when 1, finish as soon as the remaining lower count bits are
//               all zero, so trailing no-op stages are skipped.
//
// Ports:
//   clk    in   1   clock, rising edge
//   rst_n  in   1   synchronous active-low reset
//   Start  in   1   request, sampled only while idle
//   In     in  16   operand, captured on accept
//   Op     in   2   00 rotl, 01 shl, 10 rotr, 11 shr logical (captured)
//   Cnt    in   4   shift amount 0..15 (captured)
//   Busy   out  1   request in progress
//   Done   out  1   one-cycle completion pulse; Out valid from this cycle
//   Out    out 16   result register, held until the next completion
// ---------------------------------------------------------------------------
module shift_seq #(
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [15:0] In,
    input  logic [1:0]  Op,
    input  logic [3:0]  Cnt,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] Out
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] OP_ROTL = 2'b00;
    localparam logic [1:0] OP_SHL  = 2'b01;
    localparam logic [1:0] OP_ROTR = 2'b10;
    localparam logic [1:0] OP_SHR  = 2'b11;

    state_t      state_q, state_d;
    logic [1:0]  idx_q,   idx_d;
    logic [15:0] d_q,     d_d;
    logic [1:0]  op_q,    op_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
    logic [15:0] out_q,   out_d;

    // Shared shifter stage: shift d_q by 2^idx_q according to the captured op.
    logic [4:0]  stage_amt;
    logic [4:0]  stage_wrap;
    logic [15:0] stage_out;

    always_comb begin
        stage_amt  = 5'd1 << idx_q;
        stage_wrap = 5'd16 - stage_amt;
        stage_out  = d_q;
        case (op_q)
            OP_ROTL: stage_out = (d_q << stage_amt) | (d_q >> stage_wrap);
            OP_SHL:  stage_out = d_q << stage_amt;
            OP_ROTR: stage_out = (d_q >> stage_amt) | (d_q << stage_wrap);
            OP_SHR:  stage_out = d_q >> stage_amt;
            default: stage_out = d_q;
        endcase
    end

    // Count bits below the current stage; if none are set, every remaining
    // stage would be a no-op and early exit may finish now.
    logic [3:0] low_mask;
    logic       low_zero;
    logic       last_stage;
    logic [15:0] step_val;

    always_comb begin
        low_mask   = (4'b0001 << idx_q) - 4'd1;
        low_zero   = ((cnt_q & low_mask) == 4'd0);
        last_stage = (idx_q == 2'd0) || (EARLY_EXIT && low_zero);
        step_val   = cnt_q[idx_q] ? stage_out : d_q;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        d_d     = d_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    d_d     = In;
                    op_d    = Op;
                    cnt_d   = Cnt;
                    idx_d   = 2'd3;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                d_d = step_val;
                if (last_stage) begin
                    out_d   = step_val;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            d_q     <= 16'h0000;
            op_q    <= 2'b00;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            d_q     <= d_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign Out  = out_q;

endmodule

// File: tb/tb_shift_seq.sv
// ---------------------------------------------------------------------------
// tb_shift_seq -- directed bench for shift_seq.
// Two instances: dut0 with EARLY_EXIT=0, dut1 with EARLY_EXIT=1. They share
// clock, reset and operand inputs; each has its own Start.
// ---------------------------------------------------------------------------
module tb_shift_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start1;
    logic [15:0] in_s;
    logic [1:0]  op_s;
    logic [3:0]  cnt_s;
    logic        busy0, done0, busy1, done1;
    logic [15:0] out0, out1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shift_seq #(.EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .Start(start0), .In(in_s), .Op(op_s),
        .Cnt(cnt_s), .Busy(busy0), .Done(done0), .Out(out0)
    );

    shift_seq #(.EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .Start(start1), .In(in_s), .Op(op_s),
        .Cnt(cnt_s), .Busy(busy1), .Done(done1), .Out(out1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result, written as a single full-width shift.
    function automatic logic [15:0] ref_shift(input logic [15:0] a, input logic [1:0] op,
                                              input logic [3:0] cnt);
        logic [31:0] dbl;
        logic [31:0] t;
        dbl = {a, a};
        case (op)
            2'b00:   begin t = dbl << cnt; ref_shift = t[31:16]; end
            2'b01:   ref_shift = a << cnt;
            2'b10:   begin t = dbl >> cnt; ref_shift = t[15:0]; end
            default: ref_shift = a >> cnt;
        endcase
    endfunction

    // Expected edges from accept to completion.
    function automatic int ref_lat(input bit early, input logic [3:0] cnt);
        if (!early) return 4;
        if (cnt[0]) return 4;
        if (cnt[1]) return 3;
        if (cnt[2]) return 2;
        return 1;
    endfunction

    function automatic logic sel_busy(input int which);
        return (which == 0) ? busy0 : busy1;
    endfunction
    function automatic logic sel_done(input int which);
        return (which == 0) ? done0 : done1;
    endfunction
    function automatic logic [15:0] sel_out(input int which);
        return (which == 0) ? out0 : out1;
    endfunction

    // Issue one request and follow it to completion with bounded waiting.
    task automatic run_req(input int which, input logic [15:0] a, input logic [1:0] op,
                           input logic [3:0] cnt, input logic [15:0] exp_out,
                           input int exp_lat, input string tag);
        logic [15:0] prev;
        int lat;
        int busy_cycles;
        bit stable;
        bit seen;
        @(negedge clk);
        prev  = sel_out(which);
        in_s  = a;
        op_s  = op;
        cnt_s = cnt;
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        // Operand changes after accept must not matter.
        in_s  = ~a;
        op_s  = ~op;
        cnt_s = ~cnt;
        lat = 0;
        busy_cycles = 0;
        stable = 1'b1;
        seen = 1'b0;
        while (lat < 12) begin
            @(negedge clk);
            if (sel_done(which)) begin
                seen = 1'b1;
                break;
            end
            if (sel_busy(which)) busy_cycles++;
            if (sel_out(which) !== prev) stable = 1'b0;
            lat++;
        end
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy_cycles"}, busy_cycles, exp_lat);
        chk({tag, " out"}, 32'(sel_out(which)), 32'(exp_out));
        chk({tag, " out_stable"}, 32'(stable), 32'd1);
        chk({tag, " busy_in_done"}, 32'(sel_busy(which)), 32'd0);
        @(negedge clk);
        chk({tag, " done_pulse"}, 32'(sel_done(which)), 32'd0);
        chk({tag, " out_held"}, 32'(sel_out(which)), 32'(exp_out));
        $display("req %s dut%0d In=%h Op=%0d Cnt=%0d -> Out=%h lat=%0d", tag, which, a, op,
                 cnt, sel_out(which), lat);
    endtask

    initial begin
        int lat;
        bit seen;
        logic [15:0] r;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        in_s   = 16'h0;
        op_s   = 2'b00;
        cnt_s  = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy0", 32'(busy0), 32'd0);
        chk("reset done0", 32'(done0), 32'd0);
        chk("reset out0", 32'(out0), 32'h0);
        chk("reset busy1", 32'(busy1), 32'd0);
        chk("reset out1", 32'(out1), 32'h0);
        rst_n = 1'b1;

        // Hand-computed vectors.
        run_req(0, 16'h8001, 2'b00, 4'd1,  16'h0003, 4, "rotl1");
        run_req(0, 16'h1234, 2'b01, 4'd4,  16'h2340, 4, "shl4");
        run_req(0, 16'h1234, 2'b10, 4'd4,  16'h4123, 4, "rotr4");
        run_req(0, 16'h8000, 2'b11, 4'd15, 16'h0001, 4, "shr15");
        run_req(0, 16'h5A5A, 2'b11, 4'd0,  16'h5A5A, 4, "cnt0_ee0");
        run_req(1, 16'h7E81, 2'b01, 4'd0,  16'h7E81, 1, "cnt0_ee1");
        run_req(1, 16'hABCD, 2'b00, 4'd8,  16'hCDAB, 1, "rotl8_ee1");
        run_req(1, 16'h8001, 2'b00, 4'd1,  16'h0003, 4, "rotl1_ee1");
        run_req(1, 16'h00F0, 2'b11, 4'd4,  16'h000F, 2, "shr4_ee1");

        // Start held high while busy with changing operands: only the first
        // request completes, the next accept happens in the Done cycle.
        @(negedge clk);
        in_s = 16'h00F0; op_s = 2'b01; cnt_s = 4'd4; start0 = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_s = 16'hFFFF - 16'(k); op_s = 2'(k); cnt_s = 4'(k + 3);
        end
        @(negedge clk);
        chk("bb done", 32'(done0), 32'd1);
        chk("bb out", 32'(out0), 32'h0F00);
        chk("bb busy_in_done", 32'(busy0), 32'd0);
        in_s = 16'h0001; op_s = 2'b00; cnt_s = 4'd2;
        @(negedge clk);
        start0 = 1'b0;
        chk("bb reaccept busy", 32'(busy0), 32'd1);
        chk("bb reaccept done", 32'(done0), 32'd0);
        chk("bb out_held", 32'(out0), 32'h0F00);
        in_s = 16'hDEAD; op_s = 2'b11; cnt_s = 4'd7;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done0) begin seen = 1'b1; break; end
        end
        chk("bb second done", 32'(seen), 32'd1);
        chk("bb second out", 32'(out0), 32'h0004);
        $display("req backtoback dut0 first=0F00 second Out=%h", out0);

        // Reset at E2 of a request: discarded, no Done, Out cleared.
        @(negedge clk);
        in_s = 16'h1234; op_s = 2'b00; cnt_s = 4'd3; start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid busy", 32'(busy0), 32'd0);
        chk("rst_mid done", 32'(done0), 32'd0);
        chk("rst_mid out", 32'(out0), 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done0) seen = 1'b1;
        end
        chk("rst_mid no_done", 32'(seen), 32'd0);
        chk("rst_mid out_after", 32'(out0), 32'h0);
        $display("req reset_mid dut0 Out=%h", out0);
        run_req(0, 16'hC003, 2'b10, 4'd2, 16'hF000, 4, "after_rst");

        // Sweep all Op/Cnt on both instances with random operands.
        for (int w = 0; w < 2; w++) begin
            for (int o = 0; o < 4; o++) begin
                for (int c = 0; c < 16; c++) begin
                    r = 16'($urandom);
                    run_req(w, r, 2'(o), 4'(c), ref_shift(r, 2'(o), 4'(c)),
                            ref_lat(w == 1, 4'(c)), "sweep");
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
